state_serve: RTL

- Reader end of the sampled-value path. The write side accepts a free-running dti stream and is always ready; the latest value is retained.
- A request/response read interface returns the held value under full valid/ready handshaking.
- Used where a producer updates a configuration or status word at its own rate and a downstream consumer must pull it on demand, with backpressure.

---
 rtl/state_serve_pkg.sv | 27 ++
 rtl/dti_rsp_reg.sv | 56 +++++
 rtl/state_serve.sv | 131 +++++++++++++
 3 files changed

// File: rtl/state_serve_pkg.sv
// state_serve_pkg: shared types and constants for the state_serve slice.
//   holder_state_t : whether the sampled value holder has ever been written.
//   rsp_state_t    : occupancy of the one-entry read response register.
//   FRESH_BIT_W    : width of the optional "fresh" flag prepended to responses.
package state_serve_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } holder_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } rsp_state_t;

  localparam int FRESH_BIT_W = 1;

  // Chooses which value an accepted read returns. The same-cycle write is
  // used when the configuration asks for newest data, or when there is no
  // held value yet (the write is then the only thing that can be returned).
  function automatic logic take_write(input logic wr, input logic rd_new,
                                      input holder_state_t holder);
    return wr && (rd_new || (holder == EMPTY));
  endfunction

endpackage

// File: rtl/dti_rsp_reg.sv
// dti_rsp_reg: one-entry registered producer stage for a valid/ready stream.
// Ports: clk/rst (sync, active-high); load + load_data capture a new entry;
//   valid/ready/data form the producer side; can_load tells the upstream
//   logic that a load this cycle will not overwrite an unconsumed entry.
// Latency 1 cycle from load to valid; with valid && ready a new load is
// accepted in the same cycle, sustaining one transfer per cycle.
module dti_rsp_reg
  import state_serve_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  output logic          can_load,
  output logic          valid,
  input  logic          ready,
  output logic [DW-1:0] data
);

  rsp_state_t state;
  rsp_state_t state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A load always wins over the drain: the register stays PEND with the new
  // entry when the old one is consumed in the same cycle.
  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = PEND;
    end else if ((state == PEND) && ready) begin
      state_nxt = IDLE;
    end
  end

  // Data is only written on load, so it is stable while PEND and stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end
  end

  assign valid    = (state == PEND);
  assign can_load = !valid || ready;

endmodule

// File: rtl/state_serve.sv
// state_serve: holds the latest value of a free-running write stream and
// serves it to a request/response read port with full valid/ready handshake.
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   din_valid/din_ready/din_data       write stream, din_ready tied to 1
//   rd_req_valid/rd_req_ready/rd_req_data   read request token (data ignored)
//   rd_data_valid/rd_data_ready/rd_data_data read response, 1 cycle after accept
// Optional build macro STATE_SERVE_FRESH_EN: response gains an MSB flag that
// reports whether the value was written since the previous accepted read.
module state_serve
  import state_serve_pkg::*;
#(
  parameter int           W          = 8,
  parameter int           RW         = 1,
  parameter bit           RD_NEW     = 1'b1,
  parameter logic [W-1:0] INIT       = '0,
  parameter bit           INIT_VALID = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic [W-1:0]  din_data,
  input  logic          rd_req_valid,
  output logic          rd_req_ready,
  input  logic [RW-1:0] rd_req_data,
  output logic          rd_data_valid,
  input  logic          rd_data_ready,
`ifdef STATE_SERVE_FRESH_EN
  output logic [W:0]    rd_data_data
`else
  output logic [W-1:0]  rd_data_data
`endif
);

`ifdef STATE_SERVE_FRESH_EN
  localparam int DW = W + FRESH_BIT_W;
`else
  localparam int DW = W;
`endif

  holder_state_t holder;
  holder_state_t holder_nxt;
  logic [W-1:0]  held;

  logic          avail;
  logic          can_load;
  logic          accept;
  logic          use_din;
  logic [W-1:0]  load_val;
  logic [DW-1:0] load_data;

  // The request payload carries no information; fold it into a sink.
  logic          req_unused;
  assign req_unused = ^rd_req_data;

  // Writes are never throttled.
  assign din_ready = 1'b1;

  // ---------------------------------------------------------------------
  // Holder: last write always wins, EMPTY only until the first write.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      holder <= INIT_VALID ? HELD : EMPTY;
      held   <= INIT_VALID ? INIT : '0;
    end else begin
      holder <= holder_nxt;
      if (din_valid) begin
        held <= din_data;
      end
    end
  end

  always_comb begin
    holder_nxt = holder;
    if (din_valid) begin
      holder_nxt = HELD;
    end
  end

  // ---------------------------------------------------------------------
  // Request acceptance. A same-cycle write makes a value available even in
  // EMPTY, so the first read can complete alongside the first write.
  // ---------------------------------------------------------------------
  assign avail        = (holder == HELD) || din_valid;
  assign rd_req_ready = avail && can_load;
  assign accept       = rd_req_valid && rd_req_ready;

  assign use_din  = take_write(din_valid, RD_NEW, holder);
  assign load_val = use_din ? din_data : held;

`ifdef STATE_SERVE_FRESH_EN
  // Fresh flag: set by a write the reader has not yet seen, cleared when a
  // read consumes it. A write that lands together with an accept but is not
  // the value returned (RD_NEW=0 with a held value) stays unseen, so the
  // flag remains set for the next read.
  logic fresh;

  always_ff @(posedge clk) begin
    if (rst) begin
      fresh <= INIT_VALID;
    end else if (din_valid && !(accept && use_din)) begin
      fresh <= 1'b1;
    end else if (accept) begin
      fresh <= 1'b0;
    end
  end

  assign load_data = {fresh | use_din, load_val};
`else
  assign load_data = load_val;
`endif

  // ---------------------------------------------------------------------
  // Response register.
  // ---------------------------------------------------------------------
  dti_rsp_reg #(
    .DW(DW)
  ) u_rsp (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_data(load_data),
    .can_load (can_load),
    .valid    (rd_data_valid),
    .ready    (rd_data_ready),
    .data     (rd_data_data)
  );

endmodule
